// File: rtl/calc_key_sequencer.sv
// Key-entry sequencer for a BCD calculator: collects operands and operator from a
// keypad, drives an external arithmetic unit, and selects what the display shows.
module calc_key_sequencer #(
    parameter int unsigned MAX_DIGITS  = 10,
    parameter int unsigned EXEC_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_key_valid,
    input  logic [3:0]  i_key_code,
    input  logic [39:0] i_result,
    input  logic        i_err,
    input  logic        i_sign,
    output logic [39:0] o_s1,
    output logic [39:0] o_s2,
    output logic [1:0]  o_arith_func,
    output logic        o_en,
    output logic        o_sign,
    output logic [39:0] o_disp,
    output logic        o_disp_sign,
    output logic        o_disp_err,
    output logic        o_busy
);

    localparam int unsigned EW = $clog2(EXEC_CYCLES + 1);

    typedef enum logic [2:0] {S_A, S_OP, S_B, S_EXEC, S_RES, S_ERR} state_t;

    state_t        state, state_n;
    logic [39:0]   s1, s1_n, s2, s2_n, disp, disp_n;
    logic [1:0]    func, func_n, pfunc, pfunc_n;
    logic          sign, sign_n, pend, pend_n;
    logic          derr, derr_n, dsign, dsign_n, en, en_n, busy, busy_n;
    logic [3:0]    cnt, cnt_n;
    logic [EW-1:0] ecnt, ecnt_n;

    logic       is_digit, is_op, is_eq, is_clr;
    logic       a_ok, b_ok;
    logic [1:0] key_func;
    logic [3:0] first_cnt;

    assign is_digit  = i_key_valid && (i_key_code <= 4'd9);
    assign is_op     = i_key_valid && (i_key_code >= 4'd10) && (i_key_code <= 4'd13);
    assign is_eq     = i_key_valid && (i_key_code == 4'd14);
    assign is_clr    = i_key_valid && (i_key_code == 4'd15);
    // codes 10..13 map onto 00..11 through their low two bits plus two
    assign key_func  = i_key_code[1:0] + 2'd2;
    assign first_cnt = {3'b000, i_key_code != 4'd0};

    // leading zeros are not digits; a full operand ignores further entry
    assign a_ok = (cnt != 4'(MAX_DIGITS)) && !((s1 == '0) && (i_key_code == 4'd0));
    assign b_ok = (cnt != 4'(MAX_DIGITS)) && !((s2 == '0) && (i_key_code == 4'd0));

    always_comb begin
        state_n = state;
        s1_n    = s1;
        s2_n    = s2;
        func_n  = func;
        pfunc_n = pfunc;
        sign_n  = sign;
        pend_n  = pend;
        derr_n  = derr;
        cnt_n   = cnt;
        ecnt_n  = ecnt;

        if (is_clr) begin
            state_n = S_A;
            s1_n    = '0;
            s2_n    = '0;
            func_n  = '0;
            pfunc_n = '0;
            sign_n  = 1'b0;
            pend_n  = 1'b0;
            derr_n  = 1'b0;
            cnt_n   = '0;
            ecnt_n  = '0;
        end else begin
            case (state)
                S_A: begin
                    if (is_digit && a_ok) begin
                        s1_n  = {s1[35:0], i_key_code};
                        cnt_n = cnt + 4'd1;
                    end else if (is_op) begin
                        func_n  = key_func;
                        state_n = S_OP;
                    end
                end
                S_OP: begin
                    if (is_op) begin
                        func_n = key_func;
                    end else if (is_digit) begin
                        s2_n    = {36'd0, i_key_code};
                        cnt_n   = first_cnt;
                        state_n = S_B;
                    end
                end
                S_B: begin
                    if (is_digit && b_ok) begin
                        s2_n  = {s2[35:0], i_key_code};
                        cnt_n = cnt + 4'd1;
                    end else if (is_eq) begin
                        pend_n  = 1'b0;
                        ecnt_n  = '0;
                        state_n = S_EXEC;
                    end else if (is_op) begin
                        pfunc_n = key_func;
                        pend_n  = 1'b1;
                        ecnt_n  = '0;
                        state_n = S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (ecnt == EW'(EXEC_CYCLES - 1)) begin
                        if (i_err) begin
                            derr_n  = 1'b1;
                            state_n = S_ERR;
                        end else begin
                            s1_n   = i_result;
                            sign_n = i_sign;
                            s2_n   = '0;
                            if (pend) begin
                                func_n  = pfunc;
                                pend_n  = 1'b0;
                                state_n = S_OP;
                            end else begin
                                state_n = S_RES;
                            end
                        end
                    end else begin
                        ecnt_n = ecnt + EW'(1);
                    end
                end
                S_RES: begin
                    if (is_digit) begin
                        s1_n    = {36'd0, i_key_code};
                        sign_n  = 1'b0;
                        cnt_n   = first_cnt;
                        state_n = S_A;
                    end else if (is_op) begin
                        func_n  = key_func;
                        state_n = S_OP;
                    end
                end
                default: ;
            endcase
        end

        // display outputs are registered from the next-state view
        case (state_n)
            S_A, S_OP, S_RES: disp_n = s1_n;
            S_B:              disp_n = s2_n;
            S_ERR:            disp_n = '0;
            default:          disp_n = disp;
        endcase
        dsign_n = (state_n == S_B) ? 1'b0 : sign_n;
        en_n    = (state_n == S_EXEC);
        busy_n  = (state_n == S_EXEC);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_A;
            s1    <= '0;
            s2    <= '0;
            func  <= '0;
            pfunc <= '0;
            sign  <= 1'b0;
            pend  <= 1'b0;
            derr  <= 1'b0;
            cnt   <= '0;
            ecnt  <= '0;
            disp  <= '0;
            dsign <= 1'b0;
            en    <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            s1    <= s1_n;
            s2    <= s2_n;
            func  <= func_n;
            pfunc <= pfunc_n;
            sign  <= sign_n;
            pend  <= pend_n;
            derr  <= derr_n;
            cnt   <= cnt_n;
            ecnt  <= ecnt_n;
            disp  <= disp_n;
            dsign <= dsign_n;
            en    <= en_n;
            busy  <= busy_n;
        end
    end

    assign o_s1         = s1;
    assign o_s2         = s2;
    assign o_arith_func = func;
    assign o_sign       = sign;
    assign o_en         = en;
    assign o_busy       = busy;
    assign o_disp       = disp;
    assign o_disp_sign  = dsign;
    assign o_disp_err   = derr;

endmodule
